// File: rtl/lstm_fxp_pkg.sv
// Fixed-point helpers, constants and FSM states shared by the LSTM cell update path.
package lstm_fxp_pkg;

    localparam int WL   = 16;
    localparam int FRAC = 8;

    localparam logic signed [WL-1:0] FXP_ONE   = WL'(1 << FRAC);
    localparam logic signed [WL-1:0] FXP_HALF  = WL'(1 << (FRAC - 1));
    localparam logic signed [WL-1:0] FXP_2P5   = WL'(5 << (FRAC - 1));
    localparam logic signed [WL-1:0] FXP_0P375 = WL'(3 << (FRAC - 3));

    typedef enum logic [1:0] {
        WAIT_F,
        WAIT_I,
        WAIT_C
    } state_t;

    // Clamp a double-width signed value into the WL-bit signed range.
    function automatic logic signed [WL-1:0] sat_wl(input logic signed [2*WL-1:0] x);
        logic signed [2*WL-1:0] hi;
        logic signed [2*WL-1:0] lo;
        hi = {{(WL+1){1'b0}}, {(WL-1){1'b1}}};
        lo = {{(WL+1){1'b1}}, {(WL-1){1'b0}}};
        if (x > hi)
            return hi[WL-1:0];
        else if (x < lo)
            return lo[WL-1:0];
        return x[WL-1:0];
    endfunction

    // Full-precision product, arithmetic shift back to FRAC, then saturate.
    function automatic logic signed [WL-1:0] fxp_mul(input logic signed [WL-1:0] a,
                                                     input logic signed [WL-1:0] b);
        logic signed [2*WL-1:0] ae;
        logic signed [2*WL-1:0] be;
        logic signed [2*WL-1:0] p;
        ae = {{WL{a[WL-1]}}, a};
        be = {{WL{b[WL-1]}}, b};
        p  = ae * be;
        p  = p >>> FRAC;
        return sat_wl(p);
    endfunction

endpackage

// File: rtl/lstm_cell_update_if.sv
// Sequencer-to-cell-update bundle: strobes and gate read data in, cell/hidden results out.
interface lstm_cell_update_if #(
    parameter int WL    = lstm_fxp_pkg::WL,
    parameter int CNT_W = 6
);
    logic          f_done;
    logic          i_done;
    logic          c_done;
    logic [WL-1:0] mem_net1;
    logic [WL-1:0] mem_net2;
    logic [WL-1:0] c_pre;
    logic [WL-1:0] c_new;
    logic [WL-1:0] h_new;
    logic          h_valid;
    logic          seq_err;
    logic [CNT_W-1:0] elem_cnt;

    modport master (
        output f_done, i_done, c_done, mem_net1, mem_net2, c_pre,
        input  c_new, h_new, h_valid, seq_err, elem_cnt
    );

    modport slave (
        input  f_done, i_done, c_done, mem_net1, mem_net2, c_pre,
        output c_new, h_new, h_valid, seq_err, elem_cnt
    );
endinterface

// File: rtl/fxp_tanh_pwl.sv
// Three-segment piecewise-linear tanh on a signed fixed-point value (odd symmetric).
module fxp_tanh_pwl
    import lstm_fxp_pkg::*;
#(
    parameter int WL   = lstm_fxp_pkg::WL,
    parameter int FRAC = lstm_fxp_pkg::FRAC
) (
    input  logic signed [WL-1:0] x,
    output logic signed [WL-1:0] y
);
    // Package constants are exact for the default format; other formats derive their own.
    localparam bit PKG_FMT = (WL == lstm_fxp_pkg::WL) && (FRAC == lstm_fxp_pkg::FRAC);

    localparam logic [WL-1:0] HALF  = PKG_FMT ? WL'(FXP_HALF)  : WL'(1 << (FRAC - 1));
    localparam logic [WL-1:0] TWO5  = PKG_FMT ? WL'(FXP_2P5)   : WL'(5 << (FRAC - 1));
    localparam logic [WL-1:0] ONE   = PKG_FMT ? WL'(FXP_ONE)   : WL'(1 << FRAC);
    localparam logic [WL-1:0] P375  = PKG_FMT ? WL'(FXP_0P375) : WL'(3 << (FRAC - 3));
    localparam logic [WL-1:0] MAX_V = {1'b0, {(WL-1){1'b1}}};
    localparam logic [WL-1:0] MIN_V = {1'b1, {(WL-1){1'b0}}};

    logic          neg;
    logic [WL-1:0] a;
    logic [WL-1:0] m;

    // Magnitude, segment select, then restore the sign; the most negative input clamps to max magnitude.
    always_comb begin
        neg = x[WL-1];
        if (x == MIN_V)
            a = MAX_V;
        else if (neg)
            a = ~x + 1'b1;
        else
            a = x;

        if (a < HALF)
            m = a;
        else if (a < TWO5)
            m = (a >> 2) + P375;
        else
            m = ONE;

        y = neg ? (~m + 1'b1) : m;
    end
endmodule

// File: rtl/lstm_cell_update.sv
// Element-wise LSTM update: c = f*c_pre + i*g (combinational), h = o*tanh(c) (two-stage pipeline).
module lstm_cell_update
    import lstm_fxp_pkg::*;
#(
    parameter int N_ELEM = 64
) (
    input  logic clk,
    input  logic rst,
    lstm_cell_update_if.slave bus
);
    localparam int CNT_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    state_t state;

    logic signed [WL-1:0] f_q;
    logic signed [WL-1:0] ig_q;
    logic signed [WL-1:0] c_q;
    logic signed [WL-1:0] o_q;
    logic                 v_c;
    logic signed [WL-1:0] t_q;
    logic signed [WL-1:0] o_t_q;
    logic                 v_t;
    logic signed [WL-1:0] h_q;
    logic                 h_valid_q;
    logic                 seq_err_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 viol;
    logic signed [WL-1:0] fc;
    logic signed [WL:0]   sum;
    logic signed [2*WL-1:0] sum_ext;
    logic signed [WL-1:0] c_new_w;
    logic signed [WL-1:0] t_w;

    // Protocol check and the cell-state sum (f*c_pre saturated first, then WL+1-bit add).
    always_comb begin
        viol = (bus.f_done && (state != WAIT_F)) ||
               (bus.i_done && (state != WAIT_I)) ||
               (bus.c_done && (state != WAIT_C));
        fc      = fxp_mul(f_q, bus.c_pre);
        sum     = {fc[WL-1], fc} + {ig_q[WL-1], ig_q};
        sum_ext = {{(WL-1){sum[WL]}}, sum};
        c_new_w = sat_wl(sum_ext);
    end

    fxp_tanh_pwl #(
        .WL  (WL),
        .FRAC(FRAC)
    ) u_tanh (
        .x(c_q),
        .y(t_w)
    );

    // Phase sequencing; an f_done in WAIT_I restarts the element by reloading f.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_F;
            f_q       <= '0;
            ig_q      <= '0;
            c_q       <= '0;
            o_q       <= '0;
            v_c       <= 1'b0;
            cnt_q     <= '0;
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= viol;
            v_c       <= 1'b0;
            case (state)
                WAIT_F: begin
                    if (bus.f_done) begin
                        f_q   <= bus.mem_net1;
                        state <= WAIT_I;
                    end
                end
                WAIT_I: begin
                    if (bus.i_done) begin
                        ig_q  <= fxp_mul(bus.mem_net1, bus.mem_net2);
                        state <= WAIT_C;
                    end else if (bus.f_done) begin
                        f_q <= bus.mem_net1;
                    end
                end
                WAIT_C: begin
                    if (bus.c_done) begin
                        c_q   <= c_new_w;
                        o_q   <= bus.mem_net1;
                        v_c   <= 1'b1;
                        cnt_q <= (cnt_q == CNT_W'(N_ELEM - 1)) ? '0 : cnt_q + 1'b1;
                        state <= WAIT_F;
                    end
                end
                default: state <= WAIT_F;
            endcase
        end
    end

    // Stage 1: tanh of the stored cell state; o travels alongside so back-to-back updates don't collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q   <= '0;
            o_t_q <= '0;
            v_t   <= 1'b0;
        end else begin
            v_t <= v_c;
            if (v_c) begin
                t_q   <= t_w;
                o_t_q <= o_q;
            end
        end
    end

    // Stage 2: hidden output and its one-cycle valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q       <= '0;
            h_valid_q <= 1'b0;
        end else begin
            h_valid_q <= v_t;
            if (v_t)
                h_q <= fxp_mul(o_t_q, t_q);
        end
    end

    assign bus.c_new    = c_new_w;
    assign bus.h_new    = h_q;
    assign bus.h_valid  = h_valid_q;
    assign bus.seq_err  = seq_err_q;
    assign bus.elem_cnt = cnt_q;
endmodule

// File: tb/tb_lstm_cell_update.sv
// Scoreboard bench for lstm_cell_update: directed cases, protocol errors, wrap, reset, random traffic.
module tb_lstm_cell_update;
    localparam int WL     = 16;
    localparam int N_ELEM = 64;

    logic clk;
    logic rst;

    lstm_cell_update_if #(.WL(WL), .CNT_W(6)) bus ();

    lstm_cell_update #(.N_ELEM(N_ELEM)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        int h;
        int cyc;
        int cnt;
    } hexp_t;

    hexp_t hq[$];
    bit    exp_err[int];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state: phase 0 = waiting f, 1 = waiting i/g, 2 = waiting o/c
    int ph  = 0;
    int mf  = 0;
    int mig = 0;
    int cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    // real-valued product a*b/256 rounded toward -inf, then clamped
    function automatic int fmul(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return sat16(p >>> 8);
    endfunction

    // tanh approximation: identity below 0.5, slope 1/4 offset 0.375 up to 2.5, 1.0 above
    function automatic int tanh_ref(input int x);
        int a;
        int y;
        a = (x < 0) ? -x : x;
        if (a > 32767) a = 32767;
        if (a < 128)      y = a;
        else if (a < 640) y = (a / 4) + 96;
        else              y = 256;
        return (x < 0) ? -y : y;
    endfunction

    function automatic int rv();
        if ($urandom_range(0, 1) == 1)
            return int'($urandom_range(0, 2047)) - 1024;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every cycle compare seq_err; on h_valid pop the oldest expected hidden output.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            chk("seq_err", int'(bus.seq_err), exp_err.exists(cyc) ? 1 : 0);
            if (bus.h_valid) begin
                if (hq.size() == 0) begin
                    chk("h_valid_spurious", int'(bus.h_valid), 0);
                end else begin
                    hexp_t e;
                    e = hq.pop_front();
                    chk("h_new", int'($signed(bus.h_new)), e.h);
                    chk("h_latency", cyc, e.cyc);
                    chk("elem_cnt", int'(bus.elem_cnt), e.cnt);
                end
            end
        end
    end

    // One sequencer cycle; the model advances alongside and records what the DUT owes.
    task automatic step(input bit f, input bit i, input bit c,
                        input int n1, input int n2, input int cp);
        bit viol;
        int cn;
        @(negedge clk);
        bus.f_done   = f;
        bus.i_done   = i;
        bus.c_done   = c;
        bus.mem_net1 = 16'(n1);
        bus.mem_net2 = 16'(n2);
        bus.c_pre    = 16'(cp);
        viol = 1'b0;
        case (ph)
            0: begin
                viol = i | c;
                if (f) begin mf = n1; ph = 1; end
            end
            1: begin
                viol = f | c;
                if (i) begin
                    mig = fmul(n1, n2);
                    ph  = 2;
                end else if (f) begin
                    mf = n1;
                end
            end
            default: begin
                viol = f | i;
                if (c) begin
                    cn = sat16(longint'(fmul(mf, cp)) + longint'(mig));
                    #1;
                    chk("c_new", int'($signed(bus.c_new)), cn);
                    cnt = (cnt + 1) % N_ELEM;
                    hq.push_back('{h: fmul(n1, tanh_ref(cn)), cyc: cyc + 3, cnt: cnt});
                    ph = 0;
                end
            end
        endcase
        if (viol) exp_err[cyc + 1] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic elem(input int f, input int i, input int g, input int o, input int cp);
        step(1, 0, 0, f, 0, 0);
        step(0, 1, 0, i, g, 0);
        step(0, 0, 1, o, 0, cp);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (hq.size() > 0 && n < 20) begin
            idle(1);
            n++;
        end
        chk("drain_pending", hq.size(), 0);
        idle(2);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_h_new"},    int'(bus.h_new),    0);
        chk({tag, "_h_valid"},  int'(bus.h_valid),  0);
        chk({tag, "_seq_err"},  int'(bus.seq_err),  0);
        chk({tag, "_elem_cnt"}, int'(bus.elem_cnt), 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.f_done = 1'b0;
        bus.i_done = 1'b0;
        bus.c_done = 1'b0;
        hq.delete();
        exp_err.delete();
        ph  = 0;
        cnt = 0;
        #1;
        check_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.f_done   = 1'b0;
        bus.i_done   = 1'b0;
        bus.c_done   = 1'b0;
        bus.mem_net1 = '0;
        bus.mem_net2 = '0;
        bus.c_pre    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // nominal, saturation, negative cell state
        elem(16'h0080, 16'h0100, 16'h0080, 16'h0080, 16'h0100);
        idle(3);
        elem(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h7FFF);
        idle(3);
        elem(0, 16'h0100, -768, 16'h0100, 16'h1234);
        drain();

        // protocol violations followed by legal traffic
        step(0, 1, 0, 16'h0100, 16'h0100, 0);
        idle(1);
        step(1, 0, 0, 16'h0100, 0, 0);
        step(0, 1, 1, 16'h0080, 16'h0100, 0);
        step(0, 0, 1, 16'h0100, 0, 16'h0200);
        idle(3);
        step(0, 0, 1, 16'h0100, 0, 16'h0200);
        step(1, 0, 0, 16'h0040, 0, 0);
        step(1, 0, 0, -512, 0, 0);
        step(0, 1, 0, 16'h0100, 16'h0100, 0);
        step(1, 1, 1, 16'h0100, 0, 16'h0300);
        drain();

        // reset the cycle after i_done; no hidden output may follow
        step(1, 0, 0, 16'h0100, 0, 0);
        step(0, 1, 0, 16'h0100, 16'h0100, 0);
        mid_reset();
        idle(6);
        elem(16'h0100, 16'h0040, 16'h0200, 16'h0100, 16'h0080);
        drain();

        // full timestep at 6-cycle cadence; counter must come back to zero
        mid_reset();
        for (int e = 0; e < N_ELEM; e++) begin
            elem(rv(), rv(), rv(), rv(), rv());
            idle(3);
        end
        drain();
        chk("elem_cnt_wrap", int'(bus.elem_cnt), cnt);
        chk("elem_cnt_zero", int'(bus.elem_cnt), 0);

        // random strobe traffic including collisions
        for (int k = 0; k < 600; k++) begin
            int r;
            bit f;
            bit i;
            bit c;
            r = int'($urandom_range(0, 99));
            f = (r < 25);
            i = (r >= 25) && (r < 50);
            c = (r >= 50) && (r < 75);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       f = 1'b1;
                    1:       i = 1'b1;
                    default: c = 1'b1;
                endcase
            end
            step(f, i, c, rv(), rv(), rv());
        end
        drain();
        chk("elem_cnt_final", int'(bus.elem_cnt), cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
